// File: rtl/battleship_turn_ctrl.sv
// Game-flow controller for Battleship: ship-count decision, placement, alternating turns, end of game.
// Optional player turn timer is built only when BATTLE_TURN_TIMEOUT_EN is defined.
module battleship_turn_ctrl #(
  parameter int MAX_SHIPS   = 5,
  parameter int CNT_W       = 3,
  parameter int TURN_CYCLES = 750000000,
  parameter int TMR_W       = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] ship_cnt_sel,
  input  logic             place_confirm,
  input  logic             pc_place_done,
  input  logic             player_fire,
  input  logic             fire_result_vld,
  input  logic             fire_sunk,
  input  logic             pc_fire_ack,
  input  logic             pc_fire_sunk,
  input  logic             restart,
  output logic [2:0]       state_o,
  output logic             decision,
  output logic             colocation_ships,
  output logic             pc_setup,
  output logic             player_turn,
  output logic             pc_turn,
  output logic             is_victory,
  output logic             is_defeat,
  output logic             pc_fire_req,
  output logic [CNT_W-1:0] ships_target,
  output logic [CNT_W-1:0] player_ships_left,
  output logic [CNT_W-1:0] pc_ships_left,
  output logic [TMR_W-1:0] turn_timer_left,
  output logic             turn_timeout
);

  typedef enum logic [2:0] {
    DECISION    = 3'b000,
    COLOCATION  = 3'b001,
    SETUP       = 3'b010,
    PLAYER_TURN = 3'b011,
    PLAYER_WAIT = 3'b100,
    PC_TURN     = 3'b101,
    VICTORY     = 3'b110,
    DEFEAT      = 3'b111
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SHIPS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] player_cnt;
  logic [CNT_W-1:0] pc_cnt;
  logic [CNT_W-1:0] sel_clamped;
  logic [CNT_W-1:0] pc_after_shot;
  logic [CNT_W-1:0] player_after_shot;

`ifdef BATTLE_TURN_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TURN_LOAD = TMR_W'(TURN_CYCLES);
  localparam logic [TMR_W-1:0] ONE_T     = TMR_W'(1);
  logic [TMR_W-1:0] timer_q;
  logic             timeout_q;
`endif

  // Clamp the requested fleet size and precompute saturating fleet losses.
  always_comb begin
    sel_clamped = ship_cnt_sel;
    if (ship_cnt_sel == '0)
      sel_clamped = ONE_C;
    else if (ship_cnt_sel > MAX_C)
      sel_clamped = MAX_C;
    pc_after_shot     = (fire_sunk && pc_cnt != '0) ? pc_cnt - ONE_C : pc_cnt;
    player_after_shot = (pc_fire_sunk && player_cnt != '0) ? player_cnt - ONE_C : player_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DECISION;
      target_q   <= '0;
      player_cnt <= '0;
      pc_cnt     <= '0;
`ifdef BATTLE_TURN_TIMEOUT_EN
      timer_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
`ifdef BATTLE_TURN_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        DECISION: begin
          if (start) begin
            target_q   <= sel_clamped;
            player_cnt <= '0;
            pc_cnt     <= '0;
            state      <= COLOCATION;
          end
        end
        // Completion is checked before the increment, so extra confirms are dropped.
        COLOCATION: begin
          if (player_cnt == target_q)
            state <= SETUP;
          else if (place_confirm)
            player_cnt <= player_cnt + ONE_C;
        end
        SETUP: begin
          if (pc_cnt == target_q) begin
            state <= PLAYER_TURN;
`ifdef BATTLE_TURN_TIMEOUT_EN
            timer_q <= TURN_LOAD;
`endif
          end else if (pc_place_done) begin
            pc_cnt <= pc_cnt + ONE_C;
          end
        end
        PLAYER_TURN: begin
          if (player_fire) begin
            state <= PLAYER_WAIT;
`ifdef BATTLE_TURN_TIMEOUT_EN
          end else if (timer_q <= ONE_T) begin
            state     <= PC_TURN;
            timer_q   <= '0;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q - ONE_T;
`endif
          end
        end
        PLAYER_WAIT: begin
          if (fire_result_vld) begin
            pc_cnt <= pc_after_shot;
            state  <= (pc_after_shot == '0) ? VICTORY : PC_TURN;
          end
        end
        PC_TURN: begin
          if (pc_fire_ack) begin
            player_cnt <= player_after_shot;
            if (player_after_shot == '0) begin
              state <= DEFEAT;
            end else begin
              state <= PLAYER_TURN;
`ifdef BATTLE_TURN_TIMEOUT_EN
              timer_q <= TURN_LOAD;
`endif
            end
          end
        end
        VICTORY, DEFEAT: begin
          if (restart) begin
            state      <= DECISION;
            player_cnt <= '0;
            pc_cnt     <= '0;
`ifdef BATTLE_TURN_TIMEOUT_EN
            timer_q    <= '0;
`endif
          end
        end
        default: state <= DECISION;
      endcase
    end
  end

  assign state_o           = state;
  assign decision          = (state == DECISION);
  assign colocation_ships  = (state == COLOCATION);
  assign pc_setup          = (state == SETUP);
  assign player_turn       = (state == PLAYER_TURN);
  assign pc_turn           = (state == PC_TURN);
  assign is_victory        = (state == VICTORY);
  assign is_defeat         = (state == DEFEAT);
  assign pc_fire_req       = (state == PC_TURN);
  assign ships_target      = target_q;
  assign player_ships_left = player_cnt;
  assign pc_ships_left     = pc_cnt;

`ifdef BATTLE_TURN_TIMEOUT_EN
  assign turn_timer_left = timer_q;
  assign turn_timeout    = timeout_q;
`else
  assign turn_timer_left = '0;
  assign turn_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Directed bench for battleship_turn_ctrl: clamp table plus hand-written game sequences.
// Timer checks follow BATTLE_TURN_TIMEOUT_EN as the bench is compiled.
module tb_battleship_turn_ctrl;

  localparam int CNT_W = 3;
  localparam int TMR_W = 30;
  localparam int TURN  = 10;

  localparam logic [2:0] S_DEC = 3'd0, S_COL = 3'd1, S_SET = 3'd2, S_PT = 3'd3,
                         S_PW = 3'd4, S_PC = 3'd5, S_VIC = 3'd6, S_DEF = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, place_confirm = 1'b0, pc_place_done = 1'b0;
  logic player_fire = 1'b0, fire_result_vld = 1'b0, fire_sunk = 1'b0;
  logic pc_fire_ack = 1'b0, pc_fire_sunk = 1'b0, restart = 1'b0;
  logic [CNT_W-1:0] ship_cnt_sel = '0;
  logic [2:0]       state_o;
  logic decision, colocation_ships, pc_setup, player_turn, pc_turn, is_victory, is_defeat;
  logic pc_fire_req, turn_timeout;
  logic [CNT_W-1:0] ships_target, player_ships_left, pc_ships_left;
  logic [TMR_W-1:0] turn_timer_left;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [2:0] expTarget;
  } vec_t;

  vec_t vecs[6];

  battleship_turn_ctrl #(
    .MAX_SHIPS(5), .CNT_W(CNT_W), .TURN_CYCLES(TURN), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ship_cnt_sel(ship_cnt_sel),
    .place_confirm(place_confirm), .pc_place_done(pc_place_done),
    .player_fire(player_fire), .fire_result_vld(fire_result_vld), .fire_sunk(fire_sunk),
    .pc_fire_ack(pc_fire_ack), .pc_fire_sunk(pc_fire_sunk), .restart(restart),
    .state_o(state_o), .decision(decision), .colocation_ships(colocation_ships),
    .pc_setup(pc_setup), .player_turn(player_turn), .pc_turn(pc_turn),
    .is_victory(is_victory), .is_defeat(is_defeat), .pc_fire_req(pc_fire_req),
    .ships_target(ships_target), .player_ships_left(player_ships_left),
    .pc_ships_left(pc_ships_left), .turn_timer_left(turn_timer_left),
    .turn_timeout(turn_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulsePlace();
    place_confirm = 1'b1; step(); place_confirm = 1'b0;
  endtask

  task automatic pulsePcPlace();
    pc_place_done = 1'b1; step(); pc_place_done = 1'b0;
  endtask

  task automatic pulseFire();
    player_fire = 1'b1; step(); player_fire = 1'b0;
  endtask

  task automatic pulseResult(input logic sunk);
    fire_result_vld = 1'b1; fire_sunk = sunk; step();
    fire_result_vld = 1'b0; fire_sunk = 1'b0;
  endtask

  task automatic pulseAck(input logic sunk);
    pc_fire_ack = 1'b1; pc_fire_sunk = sunk; step();
    pc_fire_ack = 1'b0; pc_fire_sunk = 1'b0;
  endtask

  // Reset, then drive the decision inputs of one table record for one edge.
  task automatic applyStimulus(input vec_t v);
    doReset();
    ship_cnt_sel = v.sel;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic setupGame(input logic [2:0] n);
    doReset();
    ship_cnt_sel = n; start = 1'b1; step(); start = 1'b0;
    repeat (n) pulsePlace();
    step();
    repeat (n) pulsePcPlace();
    step();
  endtask

  initial begin
    vecs[0] = '{"clamp_sel0", 3'd0, 3'd1};
    vecs[1] = '{"clamp_sel1", 3'd1, 3'd1};
    vecs[2] = '{"clamp_sel3", 3'd3, 3'd3};
    vecs[3] = '{"clamp_sel5", 3'd5, 3'd5};
    vecs[4] = '{"clamp_sel6", 3'd6, 3'd5};
    vecs[5] = '{"clamp_sel7", 3'd7, 3'd5};

    doReset();
    checkOutput("reset_state", state_o, S_DEC);
    checkOutput("reset_decision_flag", decision, 1);
    checkOutput("reset_target", ships_target, 0);
    checkOutput("reset_timer", turn_timer_left, 0);
    step();
    checkOutput("decision_holds_without_start", state_o, S_DEC);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_state"}, state_o, S_COL);
      checkOutput({vecs[i].name, "_target"}, ships_target, vecs[i].expTarget);
    end

    // Placement with target 3, including an ignored confirm during SETUP.
    doReset();
    ship_cnt_sel = 3'd3; start = 1'b1; step(); start = 1'b0;
    repeat (3) pulsePlace();
    checkOutput("place3_player_cnt", player_ships_left, 3);
    checkOutput("place3_still_colocation", state_o, S_COL);
    step();
    checkOutput("place3_setup", state_o, S_SET);
    checkOutput("place3_setup_flag", pc_setup, 1);
    pulsePlace();
    checkOutput("extra_confirm_ignored", player_ships_left, 3);
    repeat (3) pulsePcPlace();
    checkOutput("pcplace3_cnt", pc_ships_left, 3);
    step();
    checkOutput("place3_player_turn", state_o, S_PT);
    checkOutput("place3_player_left", player_ships_left, 3);
    checkOutput("place3_pc_left", pc_ships_left, 3);
`ifdef BATTLE_TURN_TIMEOUT_EN
    checkOutput("timer_loaded", turn_timer_left, TURN);
`else
    checkOutput("timer_tied_zero", turn_timer_left, 0);
`endif
    pulseFire();
    checkOutput("fire_to_wait", state_o, S_PW);
`ifdef BATTLE_TURN_TIMEOUT_EN
    checkOutput("timer_frozen", turn_timer_left, TURN);
`endif
    pulseAck(1'b1);
    checkOutput("ack_outside_pc_turn", player_ships_left, 3);
    pulseResult(1'b0);
    checkOutput("miss_to_pc_turn", state_o, S_PC);
    checkOutput("pc_fire_req_high", pc_fire_req, 1);
    checkOutput("miss_pc_left", pc_ships_left, 3);

    // Reset while the PC is firing.
    doReset();
    checkOutput("midgame_reset_state", state_o, S_DEC);
    checkOutput("midgame_reset_req", pc_fire_req, 0);
    checkOutput("midgame_reset_player", player_ships_left, 0);
    checkOutput("midgame_reset_pc", pc_ships_left, 0);
    checkOutput("midgame_reset_target", ships_target, 0);
    checkOutput("midgame_reset_timeout", turn_timeout, 0);

    // Victory with target 1, then restart.
    setupGame(3'd1);
    pulseFire();
    pulseResult(1'b1);
    checkOutput("victory_pc_left", pc_ships_left, 0);
    checkOutput("victory_state", state_o, S_VIC);
    checkOutput("victory_flag", is_victory, 1);
    step();
    checkOutput("victory_holds_player", player_ships_left, 1);
    restart = 1'b1; step(); restart = 1'b0;
    checkOutput("restart_to_decision", state_o, S_DEC);
    checkOutput("restart_clears_player", player_ships_left, 0);

    // Defeat with target 2; the player misses both shots.
    setupGame(3'd2);
    pulseFire();
    pulseFire();
    checkOutput("fire_ignored_in_wait", state_o, S_PW);
    pulseResult(1'b0);
    pulseAck(1'b1);
    checkOutput("defeat_first_hit", player_ships_left, 1);
    checkOutput("defeat_back_to_player", state_o, S_PT);
    pulseFire();
    pulseResult(1'b0);
    pulseAck(1'b1);
    checkOutput("defeat_second_hit", player_ships_left, 0);
    checkOutput("defeat_state", state_o, S_DEF);
    checkOutput("defeat_flag", is_defeat, 1);
    checkOutput("defeat_req_low", pc_fire_req, 0);

`ifdef BATTLE_TURN_TIMEOUT_EN
    setupGame(3'd2);
    repeat (TURN - 1) step();
    checkOutput("timer_before_expiry", turn_timer_left, 1);
    checkOutput("state_before_expiry", state_o, S_PT);
    checkOutput("no_early_timeout", turn_timeout, 0);
    step();
    checkOutput("timeout_to_pc_turn", state_o, S_PC);
    checkOutput("timeout_pulse", turn_timeout, 1);
    step();
    checkOutput("timeout_single_pulse", turn_timeout, 0);

    setupGame(3'd2);
    repeat (TURN - 1) step();
    pulseFire();
    checkOutput("fire_wins_state", state_o, S_PW);
    checkOutput("fire_wins_no_timeout", turn_timeout, 0);
`else
    begin
      int leftCnt = 0;
      int pulseCnt = 0;
      setupGame(3'd2);
      for (int i = 0; i < 100; i++) begin
        step();
        if (state_o !== S_PT) leftCnt++;
        if (turn_timeout !== 1'b0) pulseCnt++;
      end
      checkOutput("no_timer_turn_holds", leftCnt, 0);
      checkOutput("no_timer_no_pulse", pulseCnt, 0);
      checkOutput("no_timer_value_zero", turn_timer_left, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
